// File: rtl/sync_fifo_wr_arb_if.sv
// Bundle of arbiter-side signals between the requesters/FIFO and sync_fifo_wr_arb.
// master: the arbiter; slave: the producers and FIFO that surround it.
interface sync_fifo_wr_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                          enable;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [ADDR_WIDTH:0]           fifo_cnt;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          active;
    logic [15:0]                   stall_cnt;

    modport master (
        input  enable, req, req_data, fifo_cnt,
        output gnt, fifo_wr_en, fifo_wr_data, active, stall_cnt
    );

    modport slave (
        output enable, req, req_data, fifo_cnt,
        input  gnt, fifo_wr_en, fifo_wr_data, active, stall_cnt
    );
endinterface

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin arbiter sharing one sync_fifo write port among NUM_REQ producers.
// Define SYNC_FIFO_WR_ARB_STATS_EN to build the saturating FIFO-stall counter.
module sync_fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sync_fifo_wr_arb_if.master   bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = ADDR_WIDTH + 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      rrPtr_q, rrPtr_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic                  wrEn_q, wrEn_d;
    logic [DATA_WIDTH-1:0] wrData_q, wrData_d;

    logic [NUM_REQ-1:0]    eligible;
    logic [CW-1:0]         fillSum;
    logic                  stall;
    logic                  found;
    int                    winner;
    logic                  grantNow;

    // Last cycle's winner sits out one cycle so it can refresh req/req_data.
    assign eligible = bus.req & ~gnt_q;
    assign fillSum  = {1'b0, bus.fifo_cnt} + {{(CW-1){1'b0}}, wrEn_q};
    assign stall    = (fillSum >= CW'(FIFO_DEPTH));

    always_comb begin
        int idx;
        found  = 1'b0;
        winner = 0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rrPtr_q) + k) % NUM_REQ;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign grantNow = (state_q == RUN) && !stall && found;

    always_comb begin
        state_d  = state_q;
        rrPtr_d  = rrPtr_q;
        gnt_d    = '0;
        wrEn_d   = grantNow;
        wrData_d = wrData_q;
        case (state_q)
            IDLE:    if (bus.enable)  state_d = RUN;
            RUN:     if (!bus.enable) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (grantNow) begin
            gnt_d[winner] = 1'b1;
            wrData_d      = bus.req_data[winner*DATA_WIDTH +: DATA_WIDTH];
            rrPtr_d       = PTR_W'((winner + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rrPtr_q  <= '0;
            gnt_q    <= '0;
            wrEn_q   <= 1'b0;
            wrData_q <= '0;
        end else begin
            state_q  <= state_d;
            rrPtr_q  <= rrPtr_d;
            gnt_q    <= gnt_d;
            wrEn_q   <= wrEn_d;
            wrData_q <= wrData_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.fifo_wr_en   = wrEn_q;
    assign bus.fifo_wr_data = wrData_q;
    assign bus.active       = (state_q == RUN);

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    logic [15:0] stallCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= 16'h0000;
        end else if ((state_q == RUN) && (|eligible) && stall && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_q <= stallCnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stallCnt_q;
`else
    assign bus.stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Directed bench for sync_fifo_wr_arb: a per-cycle vector table plus
// hand-written sequences for asynchronous reset and stall statistics.
module tb_sync_fifo_wr_arb;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_WIDTH = 3;
    localparam int NVEC       = 24;

    localparam logic [31:0] DA = 32'h0000_00A5;
    localparam logic [31:0] DD = 32'h1312_1110;

    typedef struct {
        logic        enable;
        logic [3:0]  req;
        logic [31:0] reqData;
        logic [3:0]  fifoCnt;
        logic [3:0]  expGnt;
        logic        expWrEn;
        logic [7:0]  expWrData;
        logic        expActive;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    sync_fifo_wr_arb_if #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) bus ();

    sync_fifo_wr_arb #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic applyStimulus(input logic en, input logic [3:0] req,
                                 input logic [31:0] data, input logic [3:0] cnt);
        bus.enable   = en;
        bus.req      = req;
        bus.req_data = data;
        bus.fifo_cnt = cnt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " gnt"},       32'(bus.gnt),          32'h0);
        checkOutput({tag, " wr_en"},     32'(bus.fifo_wr_en),   32'h0);
        checkOutput({tag, " wr_data"},   32'(bus.fifo_wr_data), 32'h0);
        checkOutput({tag, " active"},    32'(bus.active),       32'h0);
        checkOutput({tag, " stall_cnt"}, 32'(bus.stall_cnt),    32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       seen;
        logic [3:0] expG;
        logic [7:0] expD;
        logic [15:0] expStall;

        //                 en    req      data cnt    gnt      wr    wdata  act
        vecs[0]  = '{1'b1, 4'b0001, DA, 4'd0, 4'b0000, 1'b0, 8'h00, 1'b1};
        vecs[1]  = '{1'b1, 4'b0001, DA, 4'd0, 4'b0001, 1'b1, 8'hA5, 1'b1};
        vecs[2]  = '{1'b1, 4'b0001, DA, 4'd0, 4'b0000, 1'b0, 8'hA5, 1'b1};
        vecs[3]  = '{1'b1, 4'b0001, DA, 4'd0, 4'b0001, 1'b1, 8'hA5, 1'b1};
        vecs[4]  = '{1'b1, 4'b0001, DA, 4'd0, 4'b0000, 1'b0, 8'hA5, 1'b1};
        vecs[5]  = '{1'b1, 4'b1111, DD, 4'd0, 4'b0010, 1'b1, 8'h11, 1'b1};
        vecs[6]  = '{1'b1, 4'b1111, DD, 4'd0, 4'b0100, 1'b1, 8'h12, 1'b1};
        vecs[7]  = '{1'b1, 4'b1111, DD, 4'd0, 4'b1000, 1'b1, 8'h13, 1'b1};
        vecs[8]  = '{1'b1, 4'b1111, DD, 4'd0, 4'b0001, 1'b1, 8'h10, 1'b1};
        vecs[9]  = '{1'b1, 4'b1111, DD, 4'd0, 4'b0010, 1'b1, 8'h11, 1'b1};
        vecs[10] = '{1'b1, 4'b0000, DD, 4'd0, 4'b0000, 1'b0, 8'h11, 1'b1};
        vecs[11] = '{1'b1, 4'b0011, DD, 4'd7, 4'b0001, 1'b1, 8'h10, 1'b1};
        vecs[12] = '{1'b1, 4'b0011, DD, 4'd7, 4'b0000, 1'b0, 8'h10, 1'b1};
        vecs[13] = '{1'b1, 4'b0011, DD, 4'd8, 4'b0000, 1'b0, 8'h10, 1'b1};
        vecs[14] = '{1'b1, 4'b0011, DD, 4'd8, 4'b0000, 1'b0, 8'h10, 1'b1};
        vecs[15] = '{1'b1, 4'b0011, DD, 4'd7, 4'b0010, 1'b1, 8'h11, 1'b1};
        vecs[16] = '{1'b1, 4'b0000, DD, 4'd7, 4'b0000, 1'b0, 8'h11, 1'b1};
        vecs[17] = '{1'b0, 4'b0100, DD, 4'd0, 4'b0100, 1'b1, 8'h12, 1'b0};
        vecs[18] = '{1'b0, 4'b0100, DD, 4'd0, 4'b0000, 1'b0, 8'h12, 1'b0};
        vecs[19] = '{1'b0, 4'b1111, DD, 4'd0, 4'b0000, 1'b0, 8'h12, 1'b0};
        vecs[20] = '{1'b1, 4'b1111, DD, 4'd0, 4'b0000, 1'b0, 8'h12, 1'b1};
        vecs[21] = '{1'b1, 4'b1111, DD, 4'd0, 4'b1000, 1'b1, 8'h13, 1'b1};
        vecs[22] = '{1'b1, 4'b1111, DD, 4'd0, 4'b0001, 1'b1, 8'h10, 1'b1};
        vecs[23] = '{1'b1, 4'b0000, DD, 4'd0, 4'b0000, 1'b0, 8'h10, 1'b1};

        applyStimulus(1'b0, 4'b0000, 32'h0, 4'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].enable, vecs[i].req, vecs[i].reqData, vecs[i].fifoCnt);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d gnt", i),     32'(bus.gnt),          32'(vecs[i].expGnt));
            checkOutput($sformatf("v%0d wr_en", i),   32'(bus.fifo_wr_en),   32'(vecs[i].expWrEn));
            checkOutput($sformatf("v%0d wr_data", i), 32'(bus.fifo_wr_data), 32'(vecs[i].expWrData));
            checkOutput($sformatf("v%0d active", i),  32'(bus.active),       32'(vecs[i].expActive));
        end

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
        expStall = 16'd3;
`else
        expStall = 16'd0;
`endif
        checkOutput("table stall_cnt", 32'(bus.stall_cnt), 32'(expStall));

        // Asynchronous reset while a write is on the port.
        @(negedge clk);
        applyStimulus(1'b1, 4'b1111, DD, 4'd0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (bus.fifo_wr_en) seen = 1'b1;
        end
        checkOutput("wr_en before reset", 32'(seen), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            expG = (k == 0) ? 4'b0000 : 4'(1 << (k - 1));
            expD = (k == 0) ? 8'h00 : 8'(8'h10 + k - 1);
            checkOutput($sformatf("restart%0d gnt", k),     32'(bus.gnt),        32'(expG));
            checkOutput($sformatf("restart%0d wr_en", k),   32'(bus.fifo_wr_en), (k == 0) ? 32'h0 : 32'h1);
            checkOutput($sformatf("restart%0d wr_data", k), 32'(bus.fifo_wr_data), 32'(expD));
        end

        // Full FIFO with a request pending: 20 stalled RUN cycles.
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(1'b1, 4'b0001, DA, 4'd8);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (21) @(posedge clk);
        #1;
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
        expStall = 16'd20;
`else
        expStall = 16'd0;
`endif
        checkOutput("stall20 stall_cnt", 32'(bus.stall_cnt), 32'(expStall));
        checkOutput("stall20 wr_en",     32'(bus.fifo_wr_en), 32'h0);
        checkOutput("stall20 active",    32'(bus.active),     32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sync_fifo_wr_arb.md
# sync_fifo_wr_arb

Round-robin write-port arbiter that shares a single `sync_fifo` write port among `NUM_REQ` producers. Each cycle it selects at most one pending requester, registers that requester's data onto the FIFO write port, and returns a one-cycle grant. It also throttles itself on the FIFO fill level so that no write ever reaches a full FIFO. It sits directly in front of the FIFO instance; the FIFO read side is untouched.

## Interface
- `NUM_REQ`, default 4: number of requesters, from 2 to 8.
- `DATA_WIDTH`, default 8: word width; matches the FIFO.
- `FIFO_DEPTH`, default 8: FIFO capacity in words.
- `ADDR_WIDTH`, default 3: log2(FIFO_DEPTH). The FIFO count is `ADDR_WIDTH+1` bits wide.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `enable`, input, 1: arbitration enable.
- `req`, input, NUM_REQ: per-requester write request. Held until granted.
- `req_data`, input, NUM_REQ*DATA_WIDTH: requester i's word is in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `fifo_cnt`, input, ADDR_WIDTH+1: current FIFO occupancy.
- `gnt`, output, NUM_REQ: registered one-hot grant, one cycle wide.
- `fifo_wr_en`, output, 1: registered FIFO write enable.
- `fifo_wr_data`, output, DATA_WIDTH: registered FIFO write data.
- `active`, output, 1: high while the FSM is in RUN.
- `stall_cnt`, output, 16: FIFO-stall statistics (see Configuration).

## Operation
- FSM, reset state IDLE:
  - IDLE → RUN when `enable`=1.
  - RUN → DRAIN when `enable`=0.
  - DRAIN → IDLE on the next cycle. DRAIN exists only to retire the write registered on the RUN→DRAIN edge. No new grant is issued in DRAIN or IDLE.
- Eligible set: `req & ~gnt`. The requester granted in the previous cycle is masked for one cycle so it can update `req`/`req_data`. As a result, a lone requester gets at most one write every 2 cycles.
- Stall: no grant when `fifo_cnt + fifo_wr_en >= FIFO_DEPTH`. Compute this in ADDR_WIDTH+2 bits. It covers the in-flight write, which `fifo_cnt` does not yet reflect. Concurrent FIFO reads are ignored, so the stall is conservative.
- Round-robin pointer `rr_ptr` (reset 0):
  - The winner is the first eligible index found searching from `rr_ptr` upward, with wrap at NUM_REQ-1 → 0.
  - After a grant to index i, `rr_ptr` = (i+1) mod NUM_REQ.
  - `rr_ptr` is unchanged when there is no grant.
- Grant cycle N (in RUN, not stalled, eligible set non-zero): at edge N+1 the block registers `gnt`=onehot(i), `fifo_wr_en`=1, and `fifo_wr_data`=requester i's slice as sampled in cycle N.
- Otherwise, at that edge: `gnt`=0 and `fifo_wr_en`=0. `fifo_wr_data` holds its last value.
- Reset values: `gnt`=0, `fifo_wr_en`=0, `fifo_wr_data`=0, `active`=0, `stall_cnt`=0, `rr_ptr`=0, FSM=IDLE.
- Reset mid-transfer: the in-flight write is dropped and `gnt` clears. Requesters must keep `req` asserted and retry.

## Timing
- Latency: 1 cycle from `req` sampled high to `gnt`/`fifo_wr_en` high.
- `gnt` and `fifo_wr_en` are asserted in the same cycle; the FIFO captures the word on the following edge.
- Requester handshake:
  - Sample `gnt[i]` high → that word is consumed.
  - In the same cycle, drop `req[i]` or present the next word.
  - `req_data[i]` must stay stable while `req[i]` is high and ungranted.
- Maximum aggregate throughput is 1 word/cycle when 2 or more requesters are active.
- `enable` low: at most one further write, issued on the RUN→DRAIN edge. After that, `fifo_wr_en`=0 from the DRAIN cycle onward.

## Configuration
- `SYNC_FIFO_WR_ARB_STATS_EN` defined:
  - `stall_cnt` increments by 1 for every cycle that is in RUN with `req & ~gnt` non-zero and the stall active.
  - It saturates at 16'hFFFF and clears only on reset.
- Not defined: `stall_cnt` is tied to 16'h0000 and no counter logic is built. The port list is identical in both builds.

## Test plan
- Reset, then `enable`=1 and `req`=4'b0001 with data 8'hA5 held → `gnt`=0001 and `fifo_wr_en`=1 with 8'hA5 one cycle later. Grants then repeat every 2 cycles.
- All 4 requesters held high with data 8'h10/11/12/13 → grant order 0,1,2,3,0… on consecutive cycles; FIFO receives 10,11,12,13.
- Both preload and the in-flight case:
  - `fifo_cnt`=7 (DEPTH 8) with `req`=0011 → exactly one write is issued, then the stall holds while `fifo_cnt`=8.
  - `fifo_cnt` dropping to 7 with no write in flight → granting resumes.
- `enable` dropped in the same cycle a grant is decided → that one write completes, then `active`=0 and no further `gnt`. `rr_ptr` resumes from the last winner+1 on re-enable.
- `rst_n` pulsed low while `fifo_wr_en`=1 → all outputs are 0 immediately (asynchronous reset). After release, arbitration restarts at index 0.
- With the stats macro defined:
  - 20 stalled cycles with a request pending → `stall_cnt`=20.
  - Forcing the counter to 16'hFFFE and then running 5 stalled cycles → 16'hFFFF.
  - Without the macro → `stall_cnt` stays 0.
